// File: rtl/mnist_param_wb_slave.sv
// mnist_param_wb_slave
//   WISHBONE slave register bank for the MNIST video pipeline parameters.
//   Holds staging copies of threshold / invert / colour mode and moves them
//   to the active outputs only on a frame boundary, so a frame is never
//   processed with a half-updated parameter set.
//
// Ports
//   clk           clock, rising edge
//   wb_rst_i      asynchronous reset, active low
//   s_wb_adr_i    word address
//   s_wb_dat_i    write data
//   s_wb_dat_o    read data, valid while s_wb_ack_o=1, otherwise 0
//   s_wb_we_i     1=write, 0=read
//   s_wb_sel_i    byte enables for writes
//   s_wb_stb_i    access strobe
//   s_wb_ack_o    one-cycle acknowledge, one cycle after the strobe is taken
//   frame_start   one-cycle pulse at the first beat of each video frame
//   param_th      active threshold
//   param_inv     active invert
//   param_mode    active colour mode
module mnist_param_wb_slave #(
  parameter int          WB_ADR_WIDTH     = 8,
  parameter int          WB_DAT_WIDTH     = 32,
  parameter int          WB_SEL_WIDTH     = WB_DAT_WIDTH / 8,
  parameter logic [31:0] CORE_ID          = 32'h527a_2210,
  parameter logic [7:0]  INIT_PARAM_TH    = 8'd127,
  parameter logic        INIT_PARAM_INV   = 1'b0,
  parameter logic [1:0]  INIT_PARAM_MODE  = 2'b10,
  parameter logic        INIT_AUTO_UPDATE = 1'b0
) (
  input  logic                    clk,
  input  logic                    wb_rst_i,
  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic                    s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o,
  input  logic                    frame_start,
  output logic [7:0]              param_th,
  output logic                    param_inv,
  output logic [1:0]              param_mode
);

  localparam logic [WB_ADR_WIDTH-1:0] ADR_CORE_ID = WB_ADR_WIDTH'(8'h00);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_CONTROL = WB_ADR_WIDTH'(8'h01);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_STATUS  = WB_ADR_WIDTH'(8'h02);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_TH      = WB_ADR_WIDTH'(8'h04);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_INV     = WB_ADR_WIDTH'(8'h05);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_MODE    = WB_ADR_WIDTH'(8'h06);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_ACTIVE  = WB_ADR_WIDTH'(8'h08);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_WAIT_RELEASE
  } state_t;

  state_t state_reg, state_next;
  logic   access_en;

  logic [7:0]  stage_th_reg;
  logic        stage_inv_reg;
  logic [1:0]  stage_mode_reg;
  logic        update_req_reg;
  logic        auto_update_reg;
  logic [15:0] frame_count_reg;
  logic        ack_reg;
  logic [WB_DAT_WIDTH-1:0] dat_reg;
  logic [WB_DAT_WIDTH-1:0] rd_mux;

  logic wr_byte0;
  logic apply;

  // Only byte 0 of the write data carries register content.
  logic unused_bits;
  assign unused_bits = &{1'b0, s_wb_dat_i[WB_DAT_WIDTH-1:8], s_wb_sel_i[WB_SEL_WIDTH-1:1]};

  // Handshake FSM: an access is taken only from IDLE, so a held strobe
  // produces a single access until the master drops it.
  always_comb begin
    state_next = state_reg;
    access_en  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (s_wb_stb_i) begin
          access_en  = 1'b1;
          state_next = ST_ACK;
        end
      end
      ST_ACK:          state_next = s_wb_stb_i ? ST_WAIT_RELEASE : ST_IDLE;
      ST_WAIT_RELEASE: if (!s_wb_stb_i) state_next = ST_IDLE;
      default:         state_next = ST_IDLE;
    endcase
  end

  assign wr_byte0 = access_en & s_wb_we_i & s_wb_sel_i[0];
  assign apply    = frame_start & (update_req_reg | auto_update_reg);

  always_comb begin
    rd_mux = '0;
    case (s_wb_adr_i)
      ADR_CORE_ID: rd_mux = WB_DAT_WIDTH'(CORE_ID);
      ADR_CONTROL: rd_mux[1:0] = {auto_update_reg, update_req_reg};
      ADR_STATUS: begin
        rd_mux[0]     = update_req_reg;
        rd_mux[31:16] = frame_count_reg;
      end
      ADR_TH:      rd_mux[7:0] = stage_th_reg;
      ADR_INV:     rd_mux[0]   = stage_inv_reg;
      ADR_MODE:    rd_mux[1:0] = stage_mode_reg;
      ADR_ACTIVE:  rd_mux[10:0] = {param_mode, param_inv, param_th};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_reg       <= ST_IDLE;
      ack_reg         <= 1'b0;
      dat_reg         <= '0;
      stage_th_reg    <= INIT_PARAM_TH;
      stage_inv_reg   <= INIT_PARAM_INV;
      stage_mode_reg  <= INIT_PARAM_MODE;
      update_req_reg  <= 1'b0;
      auto_update_reg <= INIT_AUTO_UPDATE;
      frame_count_reg <= '0;
      param_th        <= INIT_PARAM_TH;
      param_inv       <= INIT_PARAM_INV;
      param_mode      <= INIT_PARAM_MODE;
    end else begin
      state_reg <= state_next;
      ack_reg   <= access_en;
      dat_reg   <= access_en ? rd_mux : '0;

      if (wr_byte0 && s_wb_adr_i == ADR_TH)   stage_th_reg   <= s_wb_dat_i[7:0];
      if (wr_byte0 && s_wb_adr_i == ADR_INV)  stage_inv_reg  <= s_wb_dat_i[0];
      if (wr_byte0 && s_wb_adr_i == ADR_MODE) stage_mode_reg <= s_wb_dat_i[1:0];
      if (wr_byte0 && s_wb_adr_i == ADR_CONTROL) auto_update_reg <= s_wb_dat_i[1];

      // A request written in the same cycle as an apply survives it.
      if (wr_byte0 && s_wb_adr_i == ADR_CONTROL && s_wb_dat_i[0])
        update_req_reg <= 1'b1;
      else if (apply)
        update_req_reg <= 1'b0;

      // Apply samples the staging registers before any same-cycle write.
      if (apply) begin
        param_th   <= stage_th_reg;
        param_inv  <= stage_inv_reg;
        param_mode <= stage_mode_reg;
      end

      if (frame_start) frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign s_wb_ack_o = ack_reg;
  assign s_wb_dat_o = dat_reg;

endmodule
